// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the CPU/system-bus side and the OAM sprite-DMA sequencer.
// The master side supplies the CPU cycle strobe, the CPU bus and the read data
// returned by the system bus; the slave side (the DMA sequencer) returns the
// CPU stall and the DMA bus drive used by the top-level bus mux.

interface oam_dma_ctrl_if;

    // CPU cycle strobe and CPU bus
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;

    // Read data returned by the system bus
    logic [7:0]  bus_din;

    // CPU stall and DMA bus drive
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_dout;

    modport master (
        output cpu_ce,
        output cpu_addr,
        output cpu_rw,
        output cpu_dout,
        output bus_din,
        input  cpu_rdy,
        input  dma_active,
        input  dma_addr,
        input  dma_rw,
        input  dma_dout
    );

    modport slave (
        input  cpu_ce,
        input  cpu_addr,
        input  cpu_rw,
        input  cpu_dout,
        input  bus_din,
        output cpu_rdy,
        output dma_active,
        output dma_addr,
        output dma_rw,
        output dma_dout
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// NES sprite-DMA sequencer. A CPU write to DMA_REG_ADDR stalls the CPU and
// copies the 256 bytes of the written page into OAM through OAM_DATA_ADDR,
// alternating one read and one write bus cycle per byte. A dummy HALT cycle,
// plus an ALIGN cycle when needed, makes every READ land on an even CPU cycle.
// Everything advances only on clk edges qualified by cpu_ce; outputs are a
// pure decode of registered state, so they only move on those edges or reset.

module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic           clk,
    input  logic           rst,
    oam_dma_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      state;
    state_t      state_next;

    // par is 0 during even CPU cycles, counted from reset
    logic        par;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_buf;

    logic        trigger;
    logic        last_byte;

    // A CPU write to the DMA register ends this CPU cycle; a read does not count
    assign trigger   = bus.cpu_ce && !bus.cpu_rw && (bus.cpu_addr == DMA_REG_ADDR);
    assign last_byte = (idx == 8'hFF);

    // State register: only moves when the CPU cycle ends, reset wins at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the transfer sequence, frozen while cpu_ce is low
    always_comb begin
        state_next = state;
        if (bus.cpu_ce) begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state_next = HALT;
                    end
                end
                HALT: begin
                    // par=0 means HALT was even, so the next cycle is odd and
                    // needs one extra dummy cycle before the first READ
                    if (par) begin
                        state_next = READ;
                    end else begin
                        state_next = ALIGN;
                    end
                end
                ALIGN: begin
                    state_next = READ;
                end
                READ: begin
                    state_next = WRITE;
                end
                WRITE: begin
                    if (last_byte) begin
                        state_next = IDLE;
                    end else begin
                        state_next = READ;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath: cycle parity, source page, byte index and the byte in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            par      <= 1'b0;
            page     <= 8'h00;
            idx      <= 8'h00;
            data_buf <= 8'h00;
        end else if (bus.cpu_ce) begin
            par <= ~par;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page <= bus.cpu_dout;
                        idx  <= 8'h00;
                    end
                end
                READ: begin
                    data_buf <= bus.bus_din;
                end
                WRITE: begin
                    // idx stops at $FF so the final byte never wraps the index
                    if (!last_byte) begin
                        idx <= idx + 8'h01;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore output decode: each state's bus drive for the whole CPU cycle
    always_comb begin
        bus.cpu_rdy    = 1'b1;
        bus.dma_active = 1'b0;
        bus.dma_addr   = 16'h0000;
        bus.dma_rw     = 1'b1;
        bus.dma_dout   = 8'h00;
        case (state)
            IDLE: begin
            end
            HALT, ALIGN: begin
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
            end
            READ: begin
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.dma_addr   = {page, idx};
            end
            WRITE: begin
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.dma_addr   = OAM_DATA_ADDR;
                bus.dma_rw     = 1'b0;
                bus.dma_dout   = data_buf;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl. A schedule model predicts the bus drive of every CPU
// cycle from the cycle number of the last accepted trigger; the bus returns
// the low address byte XOR a key that is held constant across each transfer.

module tb_oam_dma_ctrl;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAM_REG = 16'h2004;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] bus_key;

    always #5 clk = ~clk;

    oam_dma_ctrl_if bus_if ();

    assign bus_if.bus_din = (bus_if.dma_active ? bus_if.dma_addr[7:0] : bus_if.cpu_addr[7:0]) ^ bus_key;

    oam_dma_ctrl #(
        .DMA_REG_ADDR (DMA_REG),
        .OAM_DATA_ADDR(OAM_REG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int tests;
    int fails;

    // Model state: CPU cycle number since reset and the last accepted trigger
    int         m_cycle;
    bit         m_have;
    int         m_trig;
    logic [7:0] m_page;
    logic [7:0] m_key;

    // Observations of the DUT during the latest transfer
    int          obs_stall;
    int          obs_dummy;
    int          obs_reads;
    int          obs_writes;
    int          obs_order_err;
    int          obs_bad_write;
    logic [15:0] obs_first_read;
    int          obs_first_read_par;
    logic [7:0]  obs_first_wdata;
    logic [7:0]  obs_last_wdata;

    typedef struct packed {
        logic        rdy;
        logic        active;
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  dout;
        logic        dout_valid;
    } exp_t;

    // HALT is the cycle after the trigger; the first READ is the next even cycle
    function automatic int first_read_of(input int t);
        int h;
        h = t + 1;
        return ((h % 2) == 0) ? h + 2 : h + 1;
    endfunction

    // First idle cycle after the 256 read/write pairs
    function automatic int end_of(input int t);
        return first_read_of(t) + 512;
    endfunction

    function automatic exp_t model_at(input int c);
        exp_t e;
        int   fr;
        int   k;
        e.rdy        = 1'b1;
        e.active     = 1'b0;
        e.addr       = 16'h0000;
        e.rw         = 1'b1;
        e.dout       = 8'h00;
        e.dout_valid = 1'b1;
        if (m_have && c > m_trig && c < end_of(m_trig)) begin
            fr           = first_read_of(m_trig);
            e.rdy        = 1'b0;
            e.active     = 1'b1;
            e.dout_valid = 1'b0;
            if (c >= fr) begin
                k = (c - fr) / 2;
                if (((c - fr) % 2) == 0) begin
                    e.addr = {m_page, k[7:0]};
                end else begin
                    e.addr       = OAM_REG;
                    e.rw         = 1'b0;
                    e.dout       = k[7:0] ^ m_key;
                    e.dout_valid = 1'b1;
                end
            end
        end
        return e;
    endfunction

    function automatic bit model_busy();
        return m_have && (m_cycle < end_of(m_trig));
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clk with the given CPU-side inputs, applied just after the edge
    task automatic drive(input logic ce, input logic [15:0] addr, input logic rw, input logic [7:0] dout);
        @(posedge clk);
        #1;
        bus_if.cpu_ce   = ce;
        bus_if.cpu_addr = addr;
        bus_if.cpu_rw   = rw;
        bus_if.cpu_dout = dout;
    endtask

    // One CPU cycle of random length ending in a cpu_ce pulse; returns after
    // the model has accounted for it
    task automatic apply_stimulus(input logic [15:0] addr, input logic rw, input logic [7:0] dout);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) drive(1'b0, addr, rw, dout);
        drive(1'b1, addr, rw, dout);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        logic [15:0] a;
        a = 16'($urandom);
        apply_stimulus(a, 1'b1, 8'($urandom));
    endtask

    task automatic run_dma(input logic [7:0] page, input bit want_odd, input bit inject);
        int n;
        while ((m_cycle % 2) != (want_odd ? 0 : 1)) idle_cycle();
        apply_stimulus(DMA_REG, 1'b0, page);
        n = 0;
        while (model_busy() && n < 600) begin
            if (inject && n == 150) begin
                apply_stimulus(DMA_REG, 1'b0, 8'h77);
            end else begin
                idle_cycle();
            end
            n++;
        end
        if (model_busy()) check_output("dma_timeout", 32'd1, 32'd0);
        idle_cycle();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_cpu_rdy"}, bus_if.cpu_rdy, 1'b1);
        check_output({tag, "_dma_active"}, bus_if.dma_active, 1'b0);
        check_output({tag, "_dma_rw"}, bus_if.dma_rw, 1'b1);
        check_output({tag, "_dma_addr"}, bus_if.dma_addr, 16'h0000);
        check_output({tag, "_dma_dout"}, bus_if.dma_dout, 8'h00);
    endtask

    task automatic check_transfer(input string tag, input logic [7:0] page, input int stall, input logic [7:0] key);
        check_output({tag, "_stall"}, obs_stall, stall);
        check_output({tag, "_dummy"}, obs_dummy, stall - 512);
        check_output({tag, "_reads"}, obs_reads, 256);
        check_output({tag, "_writes"}, obs_writes, 256);
        check_output({tag, "_order_err"}, obs_order_err, 0);
        check_output({tag, "_bad_write"}, obs_bad_write, 0);
        check_output({tag, "_first_read"}, obs_first_read, {page, 8'h00});
        check_output({tag, "_first_read_par"}, obs_first_read_par, 0);
        check_output({tag, "_first_wdata"}, obs_first_wdata, 8'h00 ^ key);
        check_output({tag, "_last_wdata"}, obs_last_wdata, 8'hFF ^ key);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   wr40;
        bit   odd;

        tests = 0;
        fails = 0;
        m_cycle = 0;
        m_have = 1'b0;
        m_trig = 0;
        m_page = 8'h00;
        m_key = 8'h00;
        bus_key = 8'h00;
        rst = 1'b1;
        bus_if.cpu_ce = 1'b0;
        bus_if.cpu_addr = 16'h0000;
        bus_if.cpu_rw = 1'b1;
        bus_if.cpu_dout = 8'h00;
        obs_stall = 0; obs_dummy = 0; obs_reads = 0; obs_writes = 0;
        obs_order_err = 0; obs_bad_write = 0; obs_first_read = 16'h0;
        obs_first_read_par = 0; obs_first_wdata = 8'h0; obs_last_wdata = 8'h0;

        fork
            // Compare process: every clk, outputs must match the schedule model
            forever begin
                @(negedge clk);
                if (rst) begin
                    m_cycle = 0;
                    m_have  = 1'b0;
                end else begin
                    e = model_at(m_cycle);
                    tests++;
                    if (bus_if.cpu_rdy !== e.rdy || bus_if.dma_active !== e.active ||
                        bus_if.dma_addr !== e.addr || bus_if.dma_rw !== e.rw ||
                        (e.dout_valid && bus_if.dma_dout !== e.dout)) begin
                        fails++;
                        if (fails <= 20)
                            $display("[TB] FAIL cycle %0d: got rdy=%b act=%b addr=%h rw=%b dout=%h, expected rdy=%b act=%b addr=%h rw=%b dout=%h",
                                     m_cycle, bus_if.cpu_rdy, bus_if.dma_active, bus_if.dma_addr, bus_if.dma_rw, bus_if.dma_dout,
                                     e.rdy, e.active, e.addr, e.rw, e.dout);
                    end
                    if (bus_if.cpu_ce) begin
                        if (!bus_if.cpu_rdy) obs_stall++;
                        if (bus_if.dma_active && bus_if.dma_rw) begin
                            if (bus_if.dma_addr == 16'h0000) begin
                                obs_dummy++;
                            end else if (bus_if.dma_addr[15:8] == m_page) begin
                                if (obs_reads == 0) begin
                                    obs_first_read     = bus_if.dma_addr;
                                    obs_first_read_par = m_cycle % 2;
                                end
                                if (bus_if.dma_addr[7:0] != obs_reads[7:0]) obs_order_err++;
                                obs_reads++;
                            end
                        end
                        if (bus_if.dma_active && !bus_if.dma_rw) begin
                            if (obs_writes == 0) obs_first_wdata = bus_if.dma_dout;
                            obs_last_wdata = bus_if.dma_dout;
                            if (bus_if.dma_addr != OAM_REG) obs_bad_write++;
                            obs_writes++;
                        end
                        if (!e.active && !bus_if.cpu_rw && bus_if.cpu_addr == DMA_REG) begin
                            m_have = 1'b1;
                            m_trig = m_cycle;
                            m_page = bus_if.cpu_dout;
                            m_key  = bus_key;
                            obs_stall = 0; obs_dummy = 0; obs_reads = 0; obs_writes = 0;
                            obs_order_err = 0; obs_bad_write = 0;
                        end
                        m_cycle++;
                    end
                end
            end
            begin
                #5000000;
                $display("[TB] FAIL watchdog: simulation time limit reached");
                $fatal(1, "[TB] watchdog");
            end
        join_none

        // Pin the schedule model itself
        check_output("model_first_read_odd_halt", first_read_of(10), 12);
        check_output("model_first_read_even_halt", first_read_of(11), 14);
        check_output("model_stall_odd_halt", end_of(10) - 11, 513);
        check_output("model_stall_even_halt", end_of(11) - 12, 514);

        // Reset for two clks
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("reset");

        // A CPU read of the DMA register must not start anything
        apply_stimulus(DMA_REG, 1'b1, 8'hAB);
        idle_cycle();
        idle_cycle();
        check_output("read_no_trigger_rdy", bus_if.cpu_rdy, 1'b1);
        check_output("read_no_trigger_active", bus_if.dma_active, 1'b0);

        // Odd-halt and even-halt transfers of page $02
        run_dma(8'h02, 1'b1, 1'b0);
        check_transfer("odd_halt", 8'h02, 513, 8'h00);
        run_dma(8'h02, 1'b0, 1'b0);
        check_transfer("even_halt", 8'h02, 514, 8'h00);

        // Top page must not wrap into $0000
        run_dma(8'hFF, 1'b1, 1'b0);
        check_transfer("page_ff", 8'hFF, 513, 8'h00);

        // Trigger writes mid-transfer are ignored, with a non-trivial bus key
        bus_key = 8'hA5;
        odd = 1'($urandom);
        run_dma(8'h31, odd, 1'b1);
        check_transfer("inject", 8'h31, odd ? 513 : 514, 8'hA5);
        bus_key = 8'h00;

        // Reset in the WRITE of byte $40
        while ((m_cycle % 2) != 0) idle_cycle();
        apply_stimulus(DMA_REG, 1'b0, 8'h44);
        wr40 = first_read_of(m_trig) + 2 * 8'h40 + 1;
        n = 0;
        while (m_cycle < wr40 && n < 600) begin
            idle_cycle();
            n++;
        end
        if (m_cycle != wr40) check_output("reset_mid_reach", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        check_output("pre_reset_rw", bus_if.dma_rw, 1'b0);
        check_output("pre_reset_addr", bus_if.dma_addr, OAM_REG);
        check_output("pre_reset_dout", bus_if.dma_dout, 8'h40);
        rst = 1'b1;
        bus_if.cpu_ce = 1'($urandom);
        @(posedge clk);
        #1;
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        bus_if.cpu_ce = 1'b0;
        check_output("post_reset_cycle", m_cycle, 0);
        run_dma(8'h5C, 1'b1, 1'b0);
        check_transfer("after_reset", 8'h5C, 513, 8'h00);

        // Random CPU traffic with occasional triggers and changing bus keys
        for (int i = 0; i < 4000; i++) begin
            if (!model_busy() && $urandom_range(0, 7) == 0) bus_key = 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                apply_stimulus(DMA_REG, 1'b0, 8'($urandom));
            end else begin
                apply_stimulus(16'($urandom), 1'($urandom), 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
